// File: rtl/adc_rx_pkg.sv
// rtl/adc_rx_pkg.sv - shared widths, helpers and FSM encoding for adc_frame_rx
package adc_rx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Channel tag is at least one bit wide so NUM_CH=1 still has a port.
  function automatic int ch_width(input int num_ch);
    return (num_ch <= 1) ? 1 : clog2(num_ch);
  endfunction

  function automatic int lvl_width(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - first-word-fall-through FIFO with occupancy and drop strobe
module sync_fifo_fwft
  import adc_rx_pkg::*;
#(
  parameter int WIDTH = 14,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push_i,
  input  logic [WIDTH-1:0]            din_i,
  input  logic                        pop_i,
  output logic [WIDTH-1:0]            dout_o,
  output logic                        valid_o,
  output logic [lvl_width(DEPTH)-1:0] level_o,
  output logic                        drop_o
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = lvl_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             full, pop_ok, wr_ok;

  assign full    = (level_q == LW'(DEPTH));
  assign valid_o = (level_q != '0);
  assign pop_ok  = pop_i & valid_o;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign wr_ok   = push_i & (~full | pop_ok);
  assign drop_o  = push_i & full & ~pop_ok;
  assign dout_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign level_o = level_q;

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_ok)  wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + LW'(wr_ok) - LW'(pop_ok);
    end
  end

endmodule

// File: rtl/adc_frame_rx.sv
// rtl/adc_frame_rx.sv - serial ADC frame receiver with field extract, channel tagging and output FIFO
module adc_frame_rx
  import adc_rx_pkg::*;
#(
  parameter int FRAME_BITS = 16,
  parameter int DATA_LSB   = 0,
  parameter int DATA_BITS  = 12,
  parameter int NUM_CH     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             sdata,
  input  logic                             clr_ovf,
  input  logic                             out_ready,
  output logic                             out_valid,
  output logic [DATA_BITS-1:0]             out_data,
  output logic [ch_width(NUM_CH)-1:0]      out_ch,
  output logic                             overflow,
  output logic                             busy,
  output logic [lvl_width(FIFO_DEPTH)-1:0] level
);

  localparam int CH_W = ch_width(NUM_CH);
  localparam int CW   = clog2(FRAME_BITS);

  state_e                state_q;
  logic [CW-1:0]         cnt_q;
  logic [FRAME_BITS-2:0] shreg_q;
  logic [CH_W-1:0]       ch_q, ch_nxt;
  logic                  busy_q, ovf_q;
  logic [FRAME_BITS-1:0] frame;
  logic                  last, drop;

  // The newest bit completes the frame combinationally on its sampling cycle.
  assign frame  = {shreg_q, sdata};
  assign last   = (state_q == SHIFT) && (cnt_q == CW'(FRAME_BITS - 1));
  assign ch_nxt = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + CH_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      ch_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) begin
            shreg_q <= frame[FRAME_BITS-2:0];
            cnt_q   <= CW'(1);
            state_q <= SHIFT;
            busy_q  <= 1'b1;
          end
        end
        SHIFT: begin
          shreg_q <= frame[FRAME_BITS-2:0];
          if (last) begin
            cnt_q   <= '0;
            ch_q    <= ch_nxt;
            state_q <= en ? SHIFT : IDLE;
            busy_q  <= en;
          end else if (!en) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          ovf_q <= 1'b0;
    else if (drop)    ovf_q <= 1'b1;
    else if (clr_ovf) ovf_q <= 1'b0;
  end

  sync_fifo_fwft #(
    .WIDTH(DATA_BITS + CH_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (last),
    .din_i  ({frame[DATA_LSB +: DATA_BITS], ch_q}),
    .pop_i  (out_ready),
    .dout_o ({out_data, out_ch}),
    .valid_o(out_valid),
    .level_o(level),
    .drop_o (drop)
  );

  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_adc_frame_rx.sv
// tb/tb_adc_frame_rx.sv - scoreboard bench for adc_frame_rx
module tb_adc_frame_rx;

  logic        clk = 1'b0;
  logic        rst, en, sdata, clr_ovf, out_ready;
  logic        out_valid, overflow, busy;
  logic [11:0] out_data;
  logic [1:0]  out_ch;
  logic [2:0]  level;

  int          cyc = 0;
  int          nchk = 0;
  int          nerr = 0;
  logic [13:0] exp_q[$];
  int          pop_cyc[$];
  logic [13:0] mon_e;

  adc_frame_rx #(
    .FRAME_BITS(16),
    .DATA_LSB  (2),
    .DATA_BITS (12),
    .NUM_CH    (4),
    .FIFO_DEPTH(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sdata    (sdata),
    .clr_ovf  (clr_ovf),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ch   (out_ch),
    .overflow (overflow),
    .busy     (busy),
    .level    (level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      pop_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL unexpected_word: got data 0x%0h ch %0d expected no word", out_data, out_ch);
      end else begin
        mon_e = exp_q.pop_front();
        chk("word_data", {20'd0, out_data}, {20'd0, mon_e[13:2]});
        chk("word_ch", {30'd0, out_ch}, {30'd0, mon_e[1:0]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; sdata = 1'b0; clr_ovf = 1'b0;
    tick();
    rst = 1'b0;
    exp_q.delete();
    pop_cyc.delete();
  endtask

  task automatic send_frame(input logic [15:0] f, input bit exp_push, input logic [1:0] ch,
                            input bit keep_en, input bit ready_last);
    if (exp_push) exp_q.push_back({f[13:2], ch});
    for (int i = 15; i >= 0; i--) begin
      en = 1'b1;
      sdata = f[i];
      if (i == 0 && ready_last) out_ready = 1'b1;
      tick();
    end
    if (ready_last) out_ready = 1'b0;
    if (!keep_en) en = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((out_valid || level != 0) && n < 40) begin
      tick();
      n++;
    end
    chk("drain_timeout", {31'd0, n < 40}, 32'd1);
    out_ready = 1'b0;
    chk("scoreboard_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    out_ready = 1'b0;
    do_reset();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {20'd0, out_data}, 32'd0);
    chk("rst_ch", {30'd0, out_ch}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_level", {29'd0, level}, 32'd0);

    // Single frame, latency and immediate pop
    out_ready = 1'b1;
    send_frame(16'h2AF0, 1, 2'd0, 0, 0);
    chk("t1_valid_after_last", {31'd0, out_valid}, 32'd1);
    chk("t1_level_after_last", {29'd0, level}, 32'd1);
    tick();
    chk("t1_level_drained", {29'd0, level}, 32'd0);
    chk("t1_sb_empty", exp_q.size(), 32'd0);

    // Back-to-back frames, round-robin channels
    do_reset();
    out_ready = 1'b1;
    for (int k = 1; k <= 5; k++)
      send_frame(16'(k << 2), 1, 2'((k - 1) % 4), k < 5, 0);
    tick(); tick();
    chk("t2_pop_count", pop_cyc.size(), 32'd5);
    if (pop_cyc.size() == 5)
      for (int i = 1; i < 5; i++)
        chk("t2_spacing", pop_cyc[i] - pop_cyc[i-1], 32'd16);
    chk("t2_sb_empty", exp_q.size(), 32'd0);

    // Overflow with stalled consumer
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      send_frame(16'((12'h100 + k) << 2), k < 4, 2'(k % 4), 0, 0);
      if (k == 3) begin
        chk("t3_level_full", {29'd0, level}, 32'd4);
        chk("t3_ovf_before", {31'd0, overflow}, 32'd0);
      end
      if (k == 4) begin
        chk("t3_level_held", {29'd0, level}, 32'd4);
        chk("t3_ovf_set", {31'd0, overflow}, 32'd1);
      end
    end
    drain();
    chk("t3_ovf_sticky", {31'd0, overflow}, 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t3_ovf_cleared", {31'd0, overflow}, 32'd0);

    // Push and pop together while full
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++)
      send_frame(16'((12'h200 + k) << 2), 1, 2'(k), 0, 0);
    send_frame(16'h0810, 1, 2'd0, 0, 1);
    chk("t4_level_kept", {29'd0, level}, 32'd4);
    chk("t4_no_ovf", {31'd0, overflow}, 32'd0);
    drain();

    // Abort mid-frame, then a clean frame
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      en = 1'b1; sdata = 1'b1;
      tick();
    end
    en = 1'b0;
    tick();
    chk("t5_busy_abort", {31'd0, busy}, 32'd0);
    chk("t5_level_abort", {29'd0, level}, 32'd0);
    send_frame(16'h0FFC, 1, 2'd0, 0, 0);
    tick(); tick();
    chk("t5_pop_count", pop_cyc.size(), 32'd1);
    chk("t5_sb_empty", exp_q.size(), 32'd0);

    // Reset mid-frame with buffered words
    do_reset();
    out_ready = 1'b0;
    send_frame(16'h1234, 0, 2'd0, 0, 0);
    send_frame(16'h5678, 0, 2'd1, 0, 0);
    chk("t6_level_two", {29'd0, level}, 32'd2);
    for (int i = 0; i < 9; i++) begin
      en = 1'b1; sdata = i[0];
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; en = 1'b0;
    chk("t6_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_level", {29'd0, level}, 32'd0);
    chk("t6_ovf", {31'd0, overflow}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    pop_cyc.delete();
    out_ready = 1'b1;
    send_frame(16'h2AF0, 1, 2'd0, 0, 0);
    tick(); tick();
    chk("t6_pop_count", pop_cyc.size(), 32'd1);
    chk("t6_sb_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
